// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared states, coin values and widths for the coin credit controller
package vending_pkg;

    localparam int CREDIT_W = 4;

    localparam logic [2:0] VAL_POUND   = 3'd4;
    localparam logic [2:0] VAL_PIASTER = 3'd2;
    localparam logic [2:0] VAL_NICKEL  = 3'd1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

endpackage

// File: rtl/coin_edge_detect.sv
// rtl/coin_edge_detect.sv - qualifies classifier flags into single coin events with their value
module coin_edge_detect
    import vending_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] flags,
    output logic       coin_evt,
    output logic [2:0] coin_val
);

    logic [2:0] prev_flags;
    logic       one_hot;

    // Loading the live flags during reset keeps a coin held through reset from counting.
    always_ff @(posedge clk) begin
        prev_flags <= flags;
    end

    always_comb begin
        one_hot  = 1'b0;
        coin_val = 3'd0;
        case (flags)
            3'b100: begin one_hot = 1'b1; coin_val = VAL_POUND;   end
            3'b010: begin one_hot = 1'b1; coin_val = VAL_PIASTER; end
            3'b001: begin one_hot = 1'b1; coin_val = VAL_NICKEL;  end
            default: begin one_hot = 1'b0; coin_val = 3'd0; end
        endcase
    end

    assign coin_evt = one_hot && (prev_flags == 3'b000) && !rst;

endmodule

// File: rtl/coin_credit_controller.sv
// rtl/coin_credit_controller.sv - accumulates coin credit, dispenses at price and pays change
module coin_credit_controller
    import vending_pkg::*;
#(
    parameter int PRICE      = 6,
    parameter int MAX_CREDIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Pound,
    input  logic                Piaster,
    input  logic                Nickel,
    input  logic                Cancel,
    output logic [CREDIT_W-1:0] Credit,
    output logic                Dispense,
    output logic                Change_Nickel,
    output logic                Coin_Return,
    output logic                Busy
);

    localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_t              state, state_n;
    logic [CREDIT_W-1:0] credit, credit_n;
    logic                coin_return_n;
    logic                coin_evt;
    logic [2:0]          coin_val;
    logic [CREDIT_W:0]   sum;
    logic                fits;

    coin_edge_detect u_edge (
        .clk      (clk),
        .rst      (rst),
        .flags    ({Pound, Piaster, Nickel}),
        .coin_evt (coin_evt),
        .coin_val (coin_val)
    );

    // One bit of headroom so an over-ceiling coin is caught before it wraps.
    assign sum  = {1'b0, credit} + {{(CREDIT_W-2){1'b0}}, coin_val};
    assign fits = (sum <= MAX_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            credit      <= '0;
            Coin_Return <= 1'b0;
        end else begin
            state       <= state_n;
            credit      <= credit_n;
            Coin_Return <= coin_return_n;
        end
    end

    always_comb begin
        state_n       = state;
        credit_n      = credit;
        coin_return_n = 1'b0;
        case (state)
            IDLE: begin
                if (coin_evt) begin
                    if (fits) begin
                        credit_n = sum[CREDIT_W-1:0];
                        state_n  = (sum >= PRICE_W) ? DISPENSE : COLLECT;
                    end else begin
                        coin_return_n = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (Cancel) begin
                    state_n       = CHANGE;
                    coin_return_n = coin_evt;
                end else if (coin_evt) begin
                    if (fits) begin
                        credit_n = sum[CREDIT_W-1:0];
                        if (sum >= PRICE_W) state_n = DISPENSE;
                    end else begin
                        coin_return_n = 1'b1;
                    end
                end
            end
            DISPENSE: begin
                coin_return_n = coin_evt;
                credit_n      = credit - PRICE_C;
                state_n       = (credit_n != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                coin_return_n = coin_evt;
                // Guard against a zero credit here so the register can never underflow.
                if (credit != '0) credit_n = credit - 1'b1;
                if (credit <= 1) state_n = IDLE;
            end
            default: begin
                state_n  = IDLE;
                credit_n = '0;
            end
        endcase
    end

    assign Credit        = credit;
    assign Dispense      = (state == DISPENSE);
    assign Change_Nickel = (state == CHANGE);
    assign Busy          = (state == DISPENSE) || (state == CHANGE);

endmodule

// File: tb/tb_coin_credit_controller.sv
// tb/tb_coin_credit_controller.sv - directed self-checking bench for coin_credit_controller
module tb_coin_credit_controller;
    import vending_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Pound = 1'b0, Piaster = 1'b0, Nickel = 1'b0, Cancel = 1'b0;
    logic [3:0] Credit, Credit15;
    logic       Dispense, Change_Nickel, Coin_Return, Busy;
    logic       Dispense15, Change_Nickel15, Coin_Return15, Busy15;

    int passed = 0;
    int total  = 0;
    int cn_cnt, busy_cnt, cr_seen;

    coin_credit_controller dut (
        .clk(clk), .rst(rst), .Pound(Pound), .Piaster(Piaster), .Nickel(Nickel),
        .Cancel(Cancel), .Credit(Credit), .Dispense(Dispense),
        .Change_Nickel(Change_Nickel), .Coin_Return(Coin_Return), .Busy(Busy)
    );

    coin_credit_controller #(.PRICE(15), .MAX_CREDIT(15)) dut15 (
        .clk(clk), .rst(rst), .Pound(Pound), .Piaster(Piaster), .Nickel(Nickel),
        .Cancel(Cancel), .Credit(Credit15), .Dispense(Dispense15),
        .Change_Nickel(Change_Nickel15), .Coin_Return(Coin_Return15), .Busy(Busy15)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Drives one flag vector for a single edge, then a one-cycle gap with flags low.
    task automatic coin(input logic [2:0] f);
        {Pound, Piaster, Nickel} = f;
        step();
        {Pound, Piaster, Nickel} = 3'b000;
        step();
    endtask

    task automatic count_refund(input int cycles);
        cn_cnt   = 0;
        busy_cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            if (Change_Nickel) cn_cnt++;
            if (Busy) busy_cnt++;
            step();
        end
    endtask

    initial begin
        step();
        step();
        chk("rst_credit", Credit, 0);
        chk("rst_dispense", Dispense, 0);
        chk("rst_change", Change_Nickel, 0);
        chk("rst_coin_return", Coin_Return, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_state", dut.state, IDLE);
        rst = 1'b0;
        step();

        // Nickel held three cycles counts once
        cr_seen = 0;
        Nickel = 1'b1;
        step();
        chk("nick_first", Credit, 1);
        for (int i = 0; i < 2; i++) begin
            step();
            if (Coin_Return) cr_seen++;
        end
        Nickel = 1'b0;
        step();
        if (Coin_Return) cr_seen++;
        chk("nick_held_credit", Credit, 1);
        chk("nick_state", dut.state, COLLECT);
        chk("nick_no_return", cr_seen, 0);
        Cancel = 1'b1;
        step();
        Cancel = 1'b0;
        step();
        chk("nick_cleared", Credit, 0);

        // Pound then Piaster reaches price exactly
        Pound = 1'b1;
        step();
        chk("exact_4", Credit, 4);
        Pound = 1'b0;
        step();
        Piaster = 1'b1;
        step();
        chk("exact_6", Credit, 6);
        chk("exact_dispense", Dispense, 1);
        Piaster = 1'b0;
        step();
        chk("exact_after_credit", Credit, 0);
        chk("exact_after_dispense", Dispense, 0);
        count_refund(3);
        chk("exact_no_change", cn_cnt, 0);
        chk("exact_idle", dut.state, IDLE);

        // Nickel, Pound, Pound -> 9, dispense, 3 change pulses; a coin during change is rejected
        coin(3'b001);
        chk("chg_1", Credit, 1);
        coin(3'b100);
        chk("chg_5", Credit, 5);
        Pound = 1'b1;
        step();
        Pound = 1'b0;
        chk("chg_9", Credit, 9);
        chk("chg_dispense", Dispense, 1);
        for (int i = 0; i < 3; i++) begin
            Nickel = (i == 1);
            step();
            chk("chg_credit", Credit, 3 - i);
            chk("chg_pulse", Change_Nickel, 1);
            chk("chg_busy_reject", Coin_Return, (i == 1) ? 1 : 0);
        end
        Nickel = 1'b0;
        step();
        chk("chg_done_credit", Credit, 0);
        chk("chg_done_pulse", Change_Nickel, 0);
        chk("chg_done_busy", Busy, 0);

        // Cancel with credit 5 refunds five nickels
        coin(3'b100);
        coin(3'b001);
        chk("cancel_pre", Credit, 5);
        Cancel = 1'b1;
        step();
        Cancel = 1'b0;
        count_refund(8);
        chk("cancel_pulses", cn_cnt, 5);
        chk("cancel_busy", busy_cnt, 5);
        chk("cancel_end_credit", Credit, 0);

        // Cancel on the same edge as a Pound rise: coin rejected, refund still 5
        coin(3'b100);
        coin(3'b001);
        Cancel = 1'b1;
        Pound  = 1'b1;
        step();
        Cancel = 1'b0;
        Pound  = 1'b0;
        chk("cancel_coin_return", Coin_Return, 1);
        chk("cancel_coin_credit", Credit, 5);
        count_refund(8);
        chk("cancel_coin_pulses", cn_cnt, 5);
        chk("cancel_coin_busy", busy_cnt, 5);

        // Ceiling: PRICE=MAX=15, credit 13, Pound rejected, Piaster reaches 15
        rst = 1'b1;
        step();
        rst = 1'b0;
        coin(3'b100);
        coin(3'b100);
        coin(3'b100);
        coin(3'b001);
        chk("max_13", Credit15, 13);
        Pound = 1'b1;
        step();
        Pound = 1'b0;
        chk("max_reject", Coin_Return15, 1);
        chk("max_hold", Credit15, 13);
        step();
        Piaster = 1'b1;
        step();
        Piaster = 1'b0;
        chk("max_15", Credit15, 15);
        chk("max_dispense", Dispense15, 1);
        step();
        chk("max_after", Credit15, 0);

        // Pound held through reset is never credited
        Pound = 1'b1;
        rst   = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        step();
        chk("held_rst_credit", Credit, 0);
        chk("held_rst_return", Coin_Return, 0);
        Pound = 1'b0;
        step();
        chk("held_rst_release", Credit, 0);

        // Reset during change discards the remaining refund
        coin(3'b100);
        coin(3'b001);
        Cancel = 1'b1;
        step();
        Cancel = 1'b0;
        step();
        chk("rst_chg_mid", Credit, 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_chg_credit", Credit, 0);
        chk("rst_chg_state", dut.state, IDLE);
        chk("rst_chg_pulse", Change_Nickel, 0);
        count_refund(4);
        chk("rst_chg_no_more", cn_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
